// File: rtl/fft_spectrum_bank_ctrl.sv
// Ping-pong bank controller: fills the back half of a 2xN_POINTS RAM from the FFT
// magnitude stream, swaps banks on vs rising, and sequences the display read address.
module fft_spectrum_bank_ctrl #(
  parameter int unsigned N_POINTS = 512,
  parameter int unsigned AW       = 9,
  parameter int unsigned DW       = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] fft_data,
  input  logic          fft_valid,
  input  logic          fft_eop,
  input  logic          vs,
  input  logic          data_req,
  input  logic          fft_point_done,
  output logic          ram_wr_en,
  output logic [AW:0]   ram_wr_addr,
  output logic [DW-1:0] ram_wr_data,
  output logic [AW:0]   ram_rd_addr,
  output logic [AW-1:0] fft_point_cnt,
  output logic          front_bank,
  output logic          swap_pulse,
  output logic          frame_drop,
  output logic          frame_err
);

  localparam logic [AW-1:0] LAST = AW'(N_POINTS - 1);

  typedef enum logic [1:0] {
    W_IDLE,
    W_FILL,
    W_DROP
  } wstate_t;

  wstate_t       state, state_nxt;
  logic [AW-1:0] wr_cnt;
  logic          wr_full;
  logic [AW-1:0] rd_cnt;
  logic          ready;
  logic          vs_d;

  logic          wr_go;
  logic          frame_ok;
  logic          frame_bad;
  logic          drop_go;
  logic          swap;

  assign swap          = vs & ~vs_d & ready;
  assign ram_rd_addr   = {front_bank, rd_cnt};
  assign fft_point_cnt = rd_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= W_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A first sample that also carries eop is judged in W_IDLE exactly as an eop
  // in W_FILL would be; wr_cnt is always 0 here, so the length test still holds.
  always_comb begin
    state_nxt = state;
    wr_go     = 1'b0;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    drop_go   = 1'b0;
    unique case (state)
      W_IDLE: begin
        if (fft_valid) begin
          if (ready) begin
            if (fft_eop) begin
              drop_go = 1'b1;
            end else begin
              state_nxt = W_DROP;
            end
          end else begin
            wr_go = 1'b1;
            if (fft_eop) begin
              if (wr_cnt == LAST) begin
                frame_ok = 1'b1;
              end else begin
                frame_bad = 1'b1;
              end
            end else begin
              state_nxt = W_FILL;
            end
          end
        end
      end
      W_FILL: begin
        if (fft_valid) begin
          wr_go = ~wr_full;
          if (fft_eop) begin
            state_nxt = W_IDLE;
            if (!wr_full && (wr_cnt == LAST)) begin
              frame_ok = 1'b1;
            end else begin
              frame_bad = 1'b1;
            end
          end
        end
      end
      W_DROP: begin
        if (fft_valid && fft_eop) begin
          drop_go   = 1'b1;
          state_nxt = W_IDLE;
        end
      end
      default: state_nxt = W_IDLE;
    endcase
  end

  // wr_full marks that offset N_POINTS-1 has been written, so overlong frames
  // stop writing instead of wrapping back over the start of the bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt      <= '0;
      wr_full     <= 1'b0;
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= {1'b1, {AW{1'b0}}};
      ram_wr_data <= '0;
    end else begin
      ram_wr_en <= wr_go;
      if (wr_go) begin
        ram_wr_addr <= {~front_bank, wr_cnt};
        ram_wr_data <= fft_data;
      end
      if (frame_ok || frame_bad) begin
        wr_cnt  <= '0;
        wr_full <= 1'b0;
      end else if (wr_go) begin
        if (wr_cnt == LAST) begin
          wr_full <= 1'b1;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end
    end
  end

  // ready is sampled by swap before this edge's update, so a frame completing
  // on the vs_rise cycle waits for the following frame sync.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready      <= 1'b0;
      vs_d       <= 1'b0;
      front_bank <= 1'b0;
      swap_pulse <= 1'b0;
      frame_drop <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      vs_d       <= vs;
      swap_pulse <= swap;
      frame_drop <= drop_go;
      frame_err  <= frame_bad;
      if (frame_ok) begin
        ready <= 1'b1;
      end else if (swap) begin
        ready <= 1'b0;
      end
      if (swap) begin
        front_bank <= ~front_bank;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt <= '0;
    end else if (swap || fft_point_done) begin
      rd_cnt <= '0;
    end else if (data_req) begin
      rd_cnt <= (rd_cnt == LAST) ? '0 : rd_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_spectrum_bank_ctrl.sv
// Directed bench for fft_spectrum_bank_ctrl: frame fill/swap, drop, length errors,
// vs/eop coincidence, read-counter table and mid-frame reset.
module tb_fft_spectrum_bank_ctrl;

  localparam int AW = 9;
  localparam int DW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] fft_data;
  logic          fft_valid;
  logic          fft_eop;
  logic          vs;
  logic          data_req;
  logic          fft_point_done;
  logic          ram_wr_en;
  logic [AW:0]   ram_wr_addr;
  logic [DW-1:0] ram_wr_data;
  logic [AW:0]   ram_rd_addr;
  logic [AW-1:0] fft_point_cnt;
  logic          front_bank;
  logic          swap_pulse;
  logic          frame_drop;
  logic          frame_err;

  always #5 clk = ~clk;

  fft_spectrum_bank_ctrl #(
    .N_POINTS(512),
    .AW      (AW),
    .DW      (DW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fft_data      (fft_data),
    .fft_valid     (fft_valid),
    .fft_eop       (fft_eop),
    .vs            (vs),
    .data_req      (data_req),
    .fft_point_done(fft_point_done),
    .ram_wr_en     (ram_wr_en),
    .ram_wr_addr   (ram_wr_addr),
    .ram_wr_data   (ram_wr_data),
    .ram_rd_addr   (ram_rd_addr),
    .fft_point_cnt (fft_point_cnt),
    .front_bank    (front_bank),
    .swap_pulse    (swap_pulse),
    .frame_drop    (frame_drop),
    .frame_err     (frame_err)
  );

  typedef struct {
    logic          req;
    logic          done;
    logic [AW-1:0] exp_cnt;
  } rd_vec_t;

  rd_vec_t vecs [8];

  int checks   = 0;
  int failures = 0;

  int          n_wr, n_swap, n_drop, n_err, data_bad;
  logic [AW:0] wr_min, wr_max;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clr_mon();
    n_wr     = 0;
    n_swap   = 0;
    n_drop   = 0;
    n_err    = 0;
    data_bad = 0;
    wr_min   = '1;
    wr_max   = '0;
  endtask

  // Advance one clock and observe registered outputs 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (ram_wr_en) begin
      n_wr++;
      if (ram_wr_addr < wr_min) wr_min = ram_wr_addr;
      if (ram_wr_addr > wr_max) wr_max = ram_wr_addr;
      if (ram_wr_data !== ram_wr_addr[AW-1:0]) data_bad++;
    end
    if (swap_pulse) n_swap++;
    if (frame_drop) n_drop++;
    if (frame_err)  n_err++;
  endtask

  task automatic send_frame(input int n);
    for (int i = 0; i < n; i++) begin
      fft_valid = 1'b1;
      fft_data  = DW'(i);
      fft_eop   = (i == n - 1);
      tick();
    end
    fft_valid = 1'b0;
    fft_eop   = 1'b0;
  endtask

  task automatic vs_pulse();
    vs = 1'b1;
    tick();
    vs = 1'b0;
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr_en"},   32'(ram_wr_en),     32'h0);
    chk({tag, "_wr_addr"}, 32'(ram_wr_addr),   32'h200);
    chk({tag, "_wr_data"}, 32'(ram_wr_data),   32'h0);
    chk({tag, "_rd_addr"}, 32'(ram_rd_addr),   32'h0);
    chk({tag, "_pt_cnt"},  32'(fft_point_cnt), 32'h0);
    chk({tag, "_front"},   32'(front_bank),    32'h0);
    chk({tag, "_pulses"},  32'({swap_pulse, frame_drop, frame_err}), 32'h0);
  endtask

  initial begin
    int bad;
    vecs[0] = '{req: 1'b1, done: 1'b0, exp_cnt: 9'd1};
    vecs[1] = '{req: 1'b1, done: 1'b0, exp_cnt: 9'd2};
    vecs[2] = '{req: 1'b0, done: 1'b0, exp_cnt: 9'd2};
    vecs[3] = '{req: 1'b1, done: 1'b0, exp_cnt: 9'd3};
    vecs[4] = '{req: 1'b0, done: 1'b1, exp_cnt: 9'd0};
    vecs[5] = '{req: 1'b1, done: 1'b0, exp_cnt: 9'd1};
    vecs[6] = '{req: 1'b1, done: 1'b1, exp_cnt: 9'd0};
    vecs[7] = '{req: 1'b1, done: 1'b0, exp_cnt: 9'd1};

    rst = 1'b1;
    fft_data = '0;
    fft_valid = 1'b0;
    fft_eop = 1'b0;
    vs = 1'b0;
    data_req = 1'b0;
    fft_point_done = 1'b0;
    clr_mon();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_reset_outputs("reset");

    // Full frame into bank 1, then swap.
    clr_mon();
    send_frame(512);
    tick();
    chk("f1_wr_count", n_wr, 512);
    chk("f1_wr_min", 32'(wr_min), 32'h200);
    chk("f1_wr_max", 32'(wr_max), 32'h3FF);
    chk("f1_data", data_bad, 0);
    chk("f1_err_drop", n_err + n_drop, 0);
    chk("f1_front_before_vs", 32'(front_bank), 32'h0);
    vs = 1'b1;
    tick();
    chk("f1_swap_pulse", 32'(swap_pulse), 32'h1);
    chk("f1_front_after_vs", 32'(front_bank), 32'h1);
    chk("f1_rd_addr_swap", 32'(ram_rd_addr), 32'h200);
    vs = 1'b0;
    tick();
    chk("f1_swap_width", 32'(swap_pulse), 32'h0);

    bad = 0;
    for (int i = 0; i < 512; i++) begin
      data_req = 1'b1;
      tick();
      if (ram_rd_addr !== 10'(32'h200 | ((i + 1) % 512))) bad++;
    end
    data_req = 1'b0;
    chk("rd_sweep", bad, 0);
    chk("rd_sweep_wrap", 32'(ram_rd_addr), 32'h200);

    // Two back-to-back frames, no vs: second is dropped.
    clr_mon();
    send_frame(512);
    send_frame(512);
    tick();
    chk("f2_wr_count", n_wr, 512);
    chk("f2_wr_range", 32'({wr_min, wr_max}), 32'({10'h000, 10'h1FF}));
    chk("f2_drop_count", n_drop, 1);
    chk("f2_no_err_swap", n_err + n_swap, 0);
    chk("f2_front_held", 32'(front_bank), 32'h1);
    repeat (5) begin
      data_req = 1'b1;
      tick();
    end
    data_req = 1'b0;
    chk("f2_rd_before_vs", 32'(ram_rd_addr), 32'h205);
    vs = 1'b1;
    tick();
    chk("f2_front_after_vs", 32'(front_bank), 32'h0);
    chk("f2_rd_cleared", 32'(ram_rd_addr), 32'h000);
    vs = 1'b0;
    tick();
    chk("f2_swap_count", n_swap, 1);

    // Short frame then long frame: both rejected, no swap.
    clr_mon();
    send_frame(300);
    tick();
    chk("short_err", n_err, 1);
    chk("short_wr_count", n_wr, 300);
    chk("short_wr_max", 32'(wr_max), 32'h32B);
    vs_pulse();
    chk("short_no_swap", n_swap, 0);
    clr_mon();
    send_frame(600);
    tick();
    chk("long_err", n_err, 1);
    chk("long_wr_count", n_wr, 512);
    chk("long_wr_max", 32'(wr_max), 32'h3FF);
    vs_pulse();
    chk("long_no_swap", n_swap, 0);
    chk("long_front", 32'(front_bank), 32'h0);

    // eop completes on the vs_rise cycle: swap deferred to the next vs.
    clr_mon();
    for (int i = 0; i < 511; i++) begin
      fft_valid = 1'b1;
      fft_data  = DW'(i);
      fft_eop   = 1'b0;
      tick();
    end
    fft_data = DW'(511);
    fft_eop  = 1'b1;
    vs       = 1'b1;
    tick();
    fft_valid = 1'b0;
    fft_eop   = 1'b0;
    tick();
    vs = 1'b0;
    tick();
    chk("coin_no_swap", n_swap, 0);
    chk("coin_front", 32'(front_bank), 32'h0);
    chk("coin_wr", 32'({n_wr[15:0], 6'(data_bad), 10'(wr_max)}), 32'({16'd512, 6'd0, 10'h3FF}));
    chk("coin_err", n_err, 0);
    vs_pulse();
    chk("coin_swap_next", n_swap, 1);
    chk("coin_front_next", 32'(front_bank), 32'h1);

    // Read-counter table (front bank is 1 here).
    fft_point_done = 1'b1;
    tick();
    fft_point_done = 1'b0;
    chk("tbl_clear", 32'(fft_point_cnt), 32'h0);
    foreach (vecs[k]) begin
      data_req       = vecs[k].req;
      fft_point_done = vecs[k].done;
      tick();
      chk($sformatf("tbl_cnt_%0d", k), 32'(fft_point_cnt), 32'(vecs[k].exp_cnt));
      chk($sformatf("tbl_addr_%0d", k), 32'(ram_rd_addr), 32'({1'b1, vecs[k].exp_cnt}));
    end
    data_req = 1'b0;
    fft_point_done = 1'b1;
    tick();
    fft_point_done = 1'b0;
    repeat (100) begin
      data_req = 1'b1;
      tick();
    end
    chk("rd_at_100", 32'(fft_point_cnt), 32'd100);
    fft_point_done = 1'b1;
    tick();
    data_req = 1'b0;
    fft_point_done = 1'b0;
    chk("rd_done_priority", 32'(fft_point_cnt), 32'd0);
    repeat (511) begin
      data_req = 1'b1;
      tick();
    end
    chk("rd_at_511", 32'(fft_point_cnt), 32'd511);
    tick();
    data_req = 1'b0;
    chk("rd_wrap_511", 32'(fft_point_cnt), 32'd0);
    chk("rd_wrap_addr", 32'(ram_rd_addr), 32'h200);

    // Reset after 200 samples of a frame.
    for (int i = 0; i < 200; i++) begin
      fft_valid = 1'b1;
      fft_data  = DW'(i);
      tick();
    end
    fft_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    clr_mon();
    send_frame(512);
    tick();
    chk("rst_wr_count", n_wr, 512);
    chk("rst_wr_range", 32'({wr_min, wr_max}), 32'({10'h200, 10'h3FF}));
    chk("rst_err_drop", n_err + n_drop + data_bad, 0);
    vs_pulse();
    chk("rst_swap", n_swap, 1);
    chk("rst_front", 32'(front_bank), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
